// File: rtl/pipe_muxtree_pkg.sv
// Sizing helpers shared by the pipelined mux tree: stage count and per-stage tree depth.
package pipe_muxtree_pkg;

  function automatic int num_stages(input int address, input int lvl);
    return (address + lvl - 1) / lvl;
  endfunction

  // First select bit above stage k, clipped to the select width.
  function automatic int stage_hi(input int k, input int address, input int lvl);
    return ((k + 1) * lvl < address) ? (k + 1) * lvl : address;
  endfunction

  function automatic int stage_levels(input int k, input int address, input int lvl);
    return stage_hi(k, address, lvl) - k * lvl;
  endfunction

endpackage

// File: rtl/pipe_muxtree_n_mux.sv
// Combinational reduction blocks: a 2-to-1 word mux and a multi-level tree of them
// that consumes select bits LSB-first, halving the candidate array per level.
module mux2to1_n #(
  parameter int n = 4
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         s,
  output logic [n-1:0] y
);
  assign y = s ? b : a;
endmodule

module mux_level_n #(
  parameter int n        = 4,
  parameter int in_count = 16,
  parameter int levels   = 4
) (
  input  logic [n-1:0]      din  [0:in_count-1],
  input  logic [levels-1:0] sel,
  output logic [n-1:0]      dout [0:(in_count >> levels)-1]
);
  for (genvar l = 0; l < levels; l++) begin : lv
    localparam int CNT = in_count >> (l + 1);
    logic [n-1:0] o [0:CNT-1];

    // Pair (2j, 2j+1) collapses to j, so the surviving index is the old one shifted right.
    for (genvar j = 0; j < CNT; j++) begin : mx
      if (l == 0) begin : g_first
        mux2to1_n #(.n(n)) u_mux (
          .a(din[2*j]),
          .b(din[2*j+1]),
          .s(sel[l]),
          .y(o[j])
        );
      end else begin : g_next
        mux2to1_n #(.n(n)) u_mux (
          .a(lv[l-1].o[2*j]),
          .b(lv[l-1].o[2*j+1]),
          .s(sel[l]),
          .y(o[j])
        );
      end
    end
  end

  assign dout = lv[levels-1].o;
endmodule

// File: rtl/pipe_muxtree_n.sv
// Pipelined 2**address-to-1 word mux, lvl select bits resolved per registered stage.
// Optional PIPE_MUXTREE_SEL_ECHO_EN carries the accepted select to sel_o alongside data_o.
module pipe_muxtree_n
  import pipe_muxtree_pkg::*;
#(
  parameter int n       = 4,
  parameter int address = 12,
  parameter int lvl     = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [n-1:0]       data_i [0:(2**address)-1],
  input  logic [address-1:0] sel,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [n-1:0]       data_o,
  output logic               valid_o,
  input  logic               ready_i
`ifdef PIPE_MUXTREE_SEL_ECHO_EN
  ,
  output logic [address-1:0] sel_o
`endif
);
  localparam int M = 2 ** address;
  localparam int S = num_stages(address, lvl);

  logic [S-1:0] vld;
  logic [S-1:0] adv;
  logic [S-1:0] load;
  logic         accept;

  assign ready_o = !vld[0] || adv[0];
  assign accept  = valid_i && ready_o;
  assign valid_o = vld[S-1];

  // Advance ripples back from the output so a full pipe can shift in one cycle.
  always_comb begin
    adv      = '0;
    adv[S-1] = vld[S-1] && ready_i;
    for (int k = S - 2; k >= 0; k--) begin
      adv[k] = vld[k] && (!vld[k+1] || adv[k+1]);
    end
  end

  always_comb begin
    load    = '0;
    load[0] = accept;
    for (int k = 1; k < S; k++) begin
      load[k] = adv[k-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld <= '0;
    end else begin
      for (int k = 0; k < S; k++) begin
        if (load[k]) begin
          vld[k] <= 1'b1;
        end else if (adv[k]) begin
          vld[k] <= 1'b0;
        end
      end
    end
  end

  for (genvar k = 0; k < S; k++) begin : stg
    localparam int LO   = k * lvl;
    localparam int LV   = stage_levels(k, address, lvl);
    localparam int HI   = LO + LV;
    localparam int ICNT = M >> LO;
    localparam int OCNT = M >> HI;
    localparam bit LAST = (k == S - 1);

    logic [n-1:0]          din    [0:ICNT-1];
    logic [address-LO-1:0] sel_in;
    logic [n-1:0]          red    [0:OCNT-1];
    logic [n-1:0]          dat_q  [0:OCNT-1];

    if (k == 0) begin : g_first
      assign din    = data_i;
      assign sel_in = sel;
    end else begin : g_next
      assign din    = stg[k-1].dat_q;
      assign sel_in = stg[k-1].g_rem.rem_q;
    end

    mux_level_n #(
      .n       (n),
      .in_count(ICNT),
      .levels  (LV)
    ) u_red (
      .din (din),
      .sel (sel_in[LV-1:0]),
      .dout(red)
    );

    // Only the output register is cleared; inner stages are qualified by vld.
    always_ff @(posedge clk_i) begin
      if (rst_i && LAST) begin
        dat_q <= '{default: '0};
      end else if (load[k]) begin
        dat_q <= red;
      end
    end

    if (!LAST) begin : g_rem
      logic [address-HI-1:0] rem_q;
      always_ff @(posedge clk_i) begin
        if (load[k]) begin
          rem_q <= sel_in[address-LO-1:LV];
        end
      end
    end

`ifdef PIPE_MUXTREE_SEL_ECHO_EN
    logic [address-1:0] echo_in;
    logic [address-1:0] echo_q;

    if (k == 0) begin : g_echo_first
      assign echo_in = sel;
    end else begin : g_echo_next
      assign echo_in = stg[k-1].echo_q;
    end

    always_ff @(posedge clk_i) begin
      if (rst_i && LAST) begin
        echo_q <= '0;
      end else if (load[k]) begin
        echo_q <= echo_in;
      end
    end
`endif
  end

  assign data_o = stg[S-1].dat_q[0];
`ifdef PIPE_MUXTREE_SEL_ECHO_EN
  assign sel_o  = stg[S-1].echo_q;
`endif

endmodule
